io_interface_adapter: RTL and testbench

Memory-mapped parallel I/O adapter with a 16-bit one-shot interval timer, sitting on the 6502 system bus at 0x0800–0x080F beside RAM and ROM. It provides two 8-bit bidirectional ports (A and B), each with its own data direction register, a timer, an interrupt flag register and a scratch byte. The bus has no read/write strobe to this block, so the direction of each access is encoded in `register_select[3]`: low = read, high = write.

---
 rtl/io_adapter_pkg.sv | 39 +++
 rtl/io_adapter_timer.sv | 49 ++++
 rtl/io_interface_adapter.sv | 95 +++++++++
 tb/tb_io_interface_adapter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/io_adapter_pkg.sv
// Register map and helpers shared by the I/O adapter and its timer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package io_adapter_pkg;

   // Read addresses (register_select[3] = 0)
   localparam logic [3:0] RD_PORTB       = 4'h0;
   localparam logic [3:0] RD_PORTA       = 4'h1;
   localparam logic [3:0] RD_DDRB        = 4'h2;
   localparam logic [3:0] RD_DDRA        = 4'h3;
   localparam logic [3:0] RD_T1_LO       = 4'h4;
   localparam logic [3:0] RD_T1_HI       = 4'h5;
   localparam logic [3:0] RD_IFR         = 4'h6;
   localparam logic [3:0] RD_SCRATCH     = 4'h7;

   // Write addresses (register_select[3] = 1)
   localparam logic [3:0] WR_ORB         = 4'h8;
   localparam logic [3:0] WR_ORA         = 4'h9;
   localparam logic [3:0] WR_DDRB        = 4'hA;
   localparam logic [3:0] WR_DDRA        = 4'hB;
   localparam logic [3:0] WR_T1_LATCH_LO = 4'hC;
   localparam logic [3:0] WR_T1_LOAD_HI  = 4'hD;
   localparam logic [3:0] WR_IFR         = 4'hE;
   localparam logic [3:0] WR_SCRATCH     = 4'hF;

   localparam int IFR_T1_BIT = 6;

   // One bidirectional port: output register plus its direction mask
   typedef struct packed {
      logic [7:0] out_reg;
      logic [7:0] ddr;
   } port_t;

   // Output-configured bits reflect the output register, input bits the pins
   function automatic logic [7:0] port_composite(input port_t p, input logic [7:0] pins);
      return (p.out_reg & p.ddr) | (pins & ~p.ddr);
   endfunction

endpackage

// File: rtl/io_adapter_timer.sv
// 16-bit one-shot down-counter with low-byte latch and sticky timeout flag.
// Latency: load of N on edge k raises flag on edge k+N+1.
// Backpressure: none; loads and clears are accepted every edge.
module io_adapter_timer
   import io_adapter_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load_lo,
   input  logic        load_hi,
   input  logic        clr_flag,
   input  logic [7:0]  data_in,
   output logic [15:0] count,
   output logic        flag
);

   logic [7:0] latch_lo;
   logic       running;

   // Low-byte latch, consumed when the high byte starts the count
   always_ff @(posedge clk) begin
      if (reset)
         latch_lo <= 8'h00;
      else if (load_lo)
         latch_lo <= data_in;
   end

   // Count/flag: reload beats expiry, expiry beats a software clear
   always_ff @(posedge clk) begin
      if (reset) begin
         count   <= 16'h0000;
         running <= 1'b0;
         flag    <= 1'b0;
      end else if (load_hi) begin
         count   <= {data_in, latch_lo};
         running <= 1'b1;
         flag    <= 1'b0;
      end else if (running && count == 16'h0000) begin
         running <= 1'b0;
         flag    <= 1'b1;
      end else begin
         if (running)
            count <= count - 16'd1;
         if (clr_flag)
            flag <= 1'b0;
      end
   end

endmodule

// File: rtl/io_interface_adapter.sv
// Memory-mapped dual 8-bit parallel port with optional one-shot timer (IA_TIMER_EN).
// Latency: reads combinational; writes visible right after the enabling edge.
// Backpressure: none; a held write repeats every edge while chip_en is high.
module io_interface_adapter
   import io_adapter_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       chip_en,
   input  logic [3:0] register_select,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   input  logic [7:0] port_a_in,
   input  logic [7:0] port_b_in,
   output logic [7:0] port_a_out,
   output logic [7:0] port_b_out
);

   port_t      port_a;
   port_t      port_b;
   logic [7:0] scratch;
   logic       wr_en;
   logic       rd_en;
   logic [15:0] t1_count;
   logic        t1_flag;

   // Bit 3 of the address carries the access direction
   assign wr_en = chip_en &  register_select[3];
   assign rd_en = chip_en & ~register_select[3];

   // Port, direction and scratch registers; idempotent under a held write
   always_ff @(posedge clk) begin
      if (reset) begin
         port_a  <= '0;
         port_b  <= '0;
         scratch <= 8'h00;
      end else if (wr_en) begin
         case (register_select)
            WR_ORB:     port_b.out_reg <= data_in;
            WR_ORA:     port_a.out_reg <= data_in;
            WR_DDRB:    port_b.ddr     <= data_in;
            WR_DDRA:    port_a.ddr     <= data_in;
            WR_SCRATCH: scratch        <= data_in;
            default:    ;
         endcase
      end
   end

`ifdef IA_TIMER_EN
   logic t1_load_lo;
   logic t1_load_hi;
   logic t1_clr;

   assign t1_load_lo = wr_en && (register_select == WR_T1_LATCH_LO);
   assign t1_load_hi = wr_en && (register_select == WR_T1_LOAD_HI);
   assign t1_clr     = wr_en && (register_select == WR_IFR) && data_in[IFR_T1_BIT];

   io_adapter_timer u_timer (
      .clk      (clk),
      .reset    (reset),
      .load_lo  (t1_load_lo),
      .load_hi  (t1_load_hi),
      .clr_flag (t1_clr),
      .data_in  (data_in),
      .count    (t1_count),
      .flag     (t1_flag)
   );
`else
   assign t1_count = 16'h0000;
   assign t1_flag  = 1'b0;
`endif

   // Read mux; idle bus value is zero
   always_comb begin
      data_out = 8'h00;
      if (rd_en) begin
         case (register_select)
            RD_PORTB:   data_out = port_composite(port_b, port_b_in);
            RD_PORTA:   data_out = port_composite(port_a, port_a_in);
            RD_DDRB:    data_out = port_b.ddr;
            RD_DDRA:    data_out = port_a.ddr;
            RD_T1_LO:   data_out = t1_count[7:0];
            RD_T1_HI:   data_out = t1_count[15:8];
            RD_IFR:     data_out = {1'b0, t1_flag, 6'b000000};
            RD_SCRATCH: data_out = scratch;
            default:    data_out = 8'h00;
         endcase
      end
   end

   // Input-configured pins drive zero
   assign port_a_out = port_a.out_reg & port_a.ddr;
   assign port_b_out = port_b.out_reg & port_b.ddr;

endmodule

// File: tb/tb_io_interface_adapter.sv
// Self-checking bench for io_interface_adapter: vector table plus timer sequences.
// Latency: samples 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_io_interface_adapter;

   logic       clk;
   logic       reset;
   logic       chip_en;
   logic [3:0] register_select;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic [7:0] port_a_in;
   logic [7:0] port_b_in;
   logic [7:0] port_a_out;
   logic [7:0] port_b_out;

`ifdef IA_TIMER_EN
   localparam bit TIMER_ON = 1'b1;
`else
   localparam bit TIMER_ON = 1'b0;
`endif

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       cs;
      logic [3:0] sel;
      logic [7:0] din;
      logic [7:0] pa;
      logic [7:0] pb;
      logic [7:0] exp_d;
      logic [7:0] exp_pa;
      logic [7:0] exp_pb;
      string      name;
   } vec_t;

   typedef struct {
      logic [7:0] d;
      logic [7:0] pa;
      logic [7:0] pb;
      string      name;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   io_interface_adapter dut (
      .clk             (clk),
      .reset           (reset),
      .chip_en         (chip_en),
      .register_select (register_select),
      .data_in         (data_in),
      .data_out        (data_out),
      .port_a_in       (port_a_in),
      .port_a_out      (port_a_out),
      .port_b_in       (port_b_in),
      .port_b_out      (port_b_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %02h want %02h", nm, act, exp);
      end
   endtask

   task automatic add(input logic cs, input logic [3:0] sel, input logic [7:0] din,
                      input logic [7:0] pa, input logic [7:0] pb, input logic [7:0] ed,
                      input logic [7:0] epa, input logic [7:0] epb, input string nm);
      vec_t v;
      v.cs = cs; v.sel = sel; v.din = din; v.pa = pa; v.pb = pb;
      v.exp_d = ed; v.exp_pa = epa; v.exp_pb = epb; v.name = nm;
      vecs.push_back(v);
   endtask

   // Single clocked write; chip_en dropped right after the edge
   task automatic wr(input logic [3:0] sel, input logic [7:0] din);
      reset = 1'b0;
      chip_en = 1'b1;
      register_select = sel;
      data_in = din;
      @(posedge clk);
      #1;
      chip_en = 1'b0;
   endtask

   task automatic tick(input int n);
      chip_en = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Combinational read between edges; expectation is zero without the timer
   // for timer registers (flag set via timer_reg)
   task automatic peek(input logic [3:0] sel, input logic [7:0] exp, input bit timer_reg, input string nm);
      exp_t e;
      exp_t got;
      e.d = (timer_reg && !TIMER_ON) ? 8'h00 : exp;
      e.pa = 8'h00; e.pb = 8'h00; e.name = nm;
      sb.push_back(e);
      chip_en = 1'b1;
      register_select = sel;
      #1;
      got = sb.pop_front();
      check(got.name, data_out, got.d);
      chip_en = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      chip_en = 1'b0;
      register_select = 4'h0;
      data_in = 8'h00;
      port_a_in = 8'h3C;
      port_b_in = 8'h55;

      // Reset state
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("rst_pa_out", port_a_out, 8'h00);
      check("rst_pb_out", port_b_out, 8'h00);
      check("rst_dout_desel", data_out, 8'h00);

      // Vector table: inputs held across one edge, outputs sampled after it
      add(1, 4'h2, 8'h00, 8'h3C, 8'h55, 8'h00, 8'h00, 8'h00, "rst_ddrb");
      add(1, 4'h3, 8'h00, 8'h3C, 8'h55, 8'h00, 8'h00, 8'h00, "rst_ddra");
      add(1, 4'h7, 8'h00, 8'h3C, 8'h55, 8'h00, 8'h00, 8'h00, "rst_scratch");
      add(1, 4'hA, 8'hF0, 8'h3C, 8'h55, 8'h00, 8'h00, 8'h00, "wr_ddrb");
      add(1, 4'h8, 8'hAA, 8'h3C, 8'h55, 8'h00, 8'h00, 8'hA0, "wr_orb");
      add(1, 4'h0, 8'h00, 8'h3C, 8'h55, 8'hA5, 8'h00, 8'hA0, "rd_portb");
      add(1, 4'h0, 8'h00, 8'h3C, 8'hFF, 8'hAF, 8'h00, 8'hA0, "rd_portb_pins");
      add(1, 4'h2, 8'h00, 8'h3C, 8'h55, 8'hF0, 8'h00, 8'hA0, "rd_ddrb");
      add(1, 4'hB, 8'h00, 8'h3C, 8'h55, 8'h00, 8'h00, 8'hA0, "wr_ddra_in");
      add(1, 4'h9, 8'hFF, 8'h3C, 8'h55, 8'h00, 8'h00, 8'hA0, "wr_ora");
      add(1, 4'h1, 8'h00, 8'h3C, 8'h55, 8'h3C, 8'h00, 8'hA0, "rd_porta_in");
      add(1, 4'hF, 8'h5A, 8'h3C, 8'h55, 8'h00, 8'h00, 8'hA0, "wr_scratch");
      add(1, 4'h7, 8'hFF, 8'h3C, 8'h55, 8'h5A, 8'h00, 8'hA0, "rd_scratch_din");
      add(1, 4'h7, 8'h00, 8'h3C, 8'h55, 8'h5A, 8'h00, 8'hA0, "rd_scratch_kept");
      add(0, 4'h7, 8'h00, 8'h3C, 8'h55, 8'h00, 8'h00, 8'hA0, "desel_dout");
      add(1, 4'hB, 8'h0F, 8'h3C, 8'h55, 8'h00, 8'h0F, 8'hA0, "wr_ddra_mix");
      add(1, 4'h1, 8'h00, 8'h3C, 8'h55, 8'h3F, 8'h0F, 8'hA0, "rd_porta_mix");
      add(0, 4'h9, 8'h00, 8'h3C, 8'h55, 8'h00, 8'h0F, 8'hA0, "desel_write");
      add(1, 4'h3, 8'h00, 8'h3C, 8'h55, 8'h0F, 8'h0F, 8'hA0, "rd_ddra");
      add(1, 4'h6, 8'h00, 8'h3C, 8'h55, 8'h00, 8'h0F, 8'hA0, "rd_ifr_idle");
      add(1, 4'h4, 8'h00, 8'h3C, 8'h55, 8'h00, 8'h0F, 8'hA0, "rd_t1lo_idle");

      for (int i = 0; i < vecs.size(); i++) begin
         exp_t e;
         exp_t got;
         chip_en = vecs[i].cs;
         register_select = vecs[i].sel;
         data_in = vecs[i].din;
         port_a_in = vecs[i].pa;
         port_b_in = vecs[i].pb;
         e.d = vecs[i].exp_d; e.pa = vecs[i].exp_pa; e.pb = vecs[i].exp_pb;
         e.name = vecs[i].name;
         sb.push_back(e);
         @(posedge clk);
         #1;
         got = sb.pop_front();
         check({got.name, "_dout"}, data_out, got.d);
         check({got.name, "_pa"}, port_a_out, got.pa);
         check({got.name, "_pb"}, port_b_out, got.pb);
      end
      chip_en = 1'b0;
      port_a_in = 8'h3C;
      port_b_in = 8'h55;

      // Timer: latch 03, start at edge k, flag at k+4
      wr(4'hC, 8'h03);
      wr(4'hD, 8'h00);
      peek(4'h4, 8'h03, 1, "t1_lo_k");
      peek(4'h5, 8'h00, 1, "t1_hi_k");
      peek(4'h6, 8'h00, 1, "t1_ifr_k");
      for (int i = 1; i <= 3; i++) begin
         tick(1);
         peek(4'h4, 8'(3 - i), 1, "t1_lo_step");
         peek(4'h6, 8'h00, 1, "t1_ifr_step");
      end
      tick(1);
      peek(4'h6, 8'h40, 1, "t1_ifr_expired");
      peek(4'h4, 8'h00, 1, "t1_lo_hold");
      tick(3);
      peek(4'h4, 8'h00, 1, "t1_lo_stopped");
      wr(4'hE, 8'h40);
      peek(4'h6, 8'h00, 1, "t1_ifr_cleared");

      // Reset mid-count stops the timer
      wr(4'hC, 8'h05);
      wr(4'hD, 8'h00);
      tick(2);
      peek(4'h4, 8'h03, 1, "rst_mid_before");
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      peek(4'h4, 8'h00, 1, "rst_mid_count");
      peek(4'h6, 8'h00, 1, "rst_mid_ifr");
      tick(8);
      peek(4'h6, 8'h00, 1, "rst_mid_no_expire");

      // Clear-write on the expiry edge: set wins
      wr(4'hC, 8'h01);
      wr(4'hD, 8'h00);
      tick(1);
      wr(4'hE, 8'h40);
      peek(4'h6, 8'h40, 1, "clr_vs_set");
      wr(4'hE, 8'h40);
      peek(4'h6, 8'h00, 1, "clr_after_set");

      // Reload on the expiry edge wins; restart while running
      wr(4'hC, 8'h02);
      wr(4'hD, 8'h00);
      tick(2);
      wr(4'hD, 8'h01);
      peek(4'h4, 8'h02, 1, "reload_lo");
      peek(4'h5, 8'h01, 1, "reload_hi");
      peek(4'h6, 8'h00, 1, "reload_ifr");
      tick(1);
      peek(4'h4, 8'h01, 1, "reload_dec");
      wr(4'hD, 8'h00);
      peek(4'h4, 8'h02, 1, "restart_lo");
      peek(4'h5, 8'h00, 1, "restart_hi");
      tick(2);
      peek(4'h6, 8'h00, 1, "restart_not_yet");
      tick(1);
      peek(4'h6, 8'h40, 1, "restart_expired");

      // Reset beats a simultaneous write
      chip_en = 1'b1;
      register_select = 4'hA;
      data_in = 8'hFF;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chip_en = 1'b0;
      check("rst_prio_pb_out", port_b_out, 8'h00);
      check("rst_prio_pa_out", port_a_out, 8'h00);
      peek(4'h2, 8'h00, 0, "rst_prio_ddrb");
      peek(4'h6, 8'h00, 1, "rst_prio_ifr");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
